// File: rtl/snoop_bus_pkg.sv
// -----------------------------------------------------------------------------
// snoop_bus_pkg
// Shared definitions for the snooping coherence bus arbiter:
//   - coherence op encodings (OP_RM, OP_WM, OP_INV; encoding 3 behaves as INV)
//   - FSM state enum
//   - field positions of the default 24-bit bus message
//   - helper telling whether an op needs a memory response
// -----------------------------------------------------------------------------
package snoop_bus_pkg;

    localparam logic [1:0] OP_RM  = 2'd0;
    localparam logic [1:0] OP_WM  = 2'd1;
    localparam logic [1:0] OP_INV = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BCAST = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Field layout of the default 24-bit message. The op field always sits
    // just below the MSB: [MSG_W-2 : MSG_W-3].
    localparam int OP_W     = 2;
    localparam int OP_MSB   = 22;
    localparam int OP_LSB   = 21;
    localparam int TAG_MSB  = 20;
    localparam int TAG_LSB  = 12;
    localparam int DATA_MSB = 11;
    localparam int DATA_LSB = 0;

    // Only misses travel to memory; invalidates (and the reserved code)
    // complete right after the broadcast.
    function automatic logic needs_mem(input logic [OP_W-1:0] op);
        return (op == OP_RM) || (op == OP_WM);
    endfunction

endpackage

// File: rtl/snoop_bus_if.sv
// -----------------------------------------------------------------------------
// snoop_bus_if
// Bundles the request, broadcast, memory-response and completion signals of
// the snooping bus.
//   master modport : caches/memory side (drives i_*, observes o_*)
//   slave  modport : arbiter side (observes i_*, drives o_*)
// Signals:
//   i_req       [N_MASTERS]        per-master request
//   i_msg       [N_MASTERS*MSG_W]  per-master message, master k at [k*MSG_W +: MSG_W]
//   i_mem_valid                    memory response strobe
//   i_mem_msg   [MSG_W]            memory response data
//   o_gnt       [N_MASTERS]        one-hot grant
//   o_bus_valid                    one-cycle broadcast strobe
//   o_bus_msg   [MSG_W]            latched message of the granted master
//   o_resp_msg  [MSG_W]            registered memory response
//   o_done      [N_MASTERS]        one-hot completion pulse
//   o_err                          timeout completion flag
// -----------------------------------------------------------------------------
interface snoop_bus_if #(
    parameter int N_MASTERS = 4,
    parameter int MSG_W     = 24
);
    logic [N_MASTERS-1:0]       i_req;
    logic [N_MASTERS*MSG_W-1:0] i_msg;
    logic                       i_mem_valid;
    logic [MSG_W-1:0]           i_mem_msg;
    logic [N_MASTERS-1:0]       o_gnt;
    logic                       o_bus_valid;
    logic [MSG_W-1:0]           o_bus_msg;
    logic [MSG_W-1:0]           o_resp_msg;
    logic [N_MASTERS-1:0]       o_done;
    logic                       o_err;

    modport master (
        output i_req, i_msg, i_mem_valid, i_mem_msg,
        input  o_gnt, o_bus_valid, o_bus_msg, o_resp_msg, o_done, o_err
    );

    modport slave (
        input  i_req, i_msg, i_mem_valid, i_mem_msg,
        output o_gnt, o_bus_valid, o_bus_msg, o_resp_msg, o_done, o_err
    );
endinterface

// File: rtl/snoop_bus_prio_pick.sv
// -----------------------------------------------------------------------------
// snoop_bus_prio_pick
// Combinational one-hot picker. Searches req_i upward from start_i with
// wrap-around and returns the first set bit.
// Ports:
//   req_i    [N]      request vector
//   start_i  [IDX_W]  index searched first (must be < N)
//   gnt_o    [N]      one-hot winner
//   idx_o    [IDX_W]  binary index of the winner
//   any_o             at least one request present
// -----------------------------------------------------------------------------
module snoop_bus_prio_pick #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] start_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    int pos;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        pos   = 0;
        for (int k = 0; k < N; k++) begin
            pos = int'(start_i) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            if (!any_o && req_i[pos]) begin
                any_o      = 1'b1;
                gnt_o[pos] = 1'b1;
                idx_o      = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/snoop_bus_arbiter.sv
// -----------------------------------------------------------------------------
// snoop_bus_arbiter
// Registered N-master arbiter for the snooping coherence bus. Grants one
// cache, broadcasts its latched message for one cycle, waits for the memory
// response (misses only) or a timeout, then pulses o_done to the winner.
//
// Ports:
//   i_clk    single clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   bus      snoop_bus_if.slave (requests, broadcast, memory response, done)
//
// Build option:
//   SNOOP_BUS_RR_EN  defined   -> round-robin arbitration
//                    undefined -> fixed priority, master 0 highest
// -----------------------------------------------------------------------------
module snoop_bus_arbiter
    import snoop_bus_pkg::*;
#(
    parameter int N_MASTERS = 4,
    parameter int MSG_W     = 24,
    parameter int TIMEOUT   = 15
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    snoop_bus_if.slave bus
);

    localparam int IDX_W = $clog2(N_MASTERS);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_BCAST = ST_BCAST;
    localparam logic [1:0] S_WAIT  = ST_WAIT;
    localparam logic [1:0] S_DONE  = ST_DONE;

    logic [1:0]           state_q,     state_d;
    logic [N_MASTERS-1:0] gnt_q,       gnt_d;
    logic                 bus_valid_q, bus_valid_d;
    logic [MSG_W-1:0]     bus_msg_q,   bus_msg_d;
    logic [MSG_W-1:0]     resp_q,      resp_d;
    logic [N_MASTERS-1:0] done_q,      done_d;
    logic                 err_q,       err_d;
    logic [CNT_W-1:0]     cnt_q,       cnt_d;

    logic [N_MASTERS-1:0] pick_gnt;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_any;
    logic [IDX_W-1:0]     pick_start;
    logic [1:0]           op;

`ifdef SNOOP_BUS_RR_EN
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    assign pick_start = ptr_q;
`else
    assign pick_start = '0;
`endif

    snoop_bus_prio_pick #(
        .N     (N_MASTERS),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i   (bus.i_req),
        .start_i (pick_start),
        .gnt_o   (pick_gnt),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    // op is taken from the latched message, so late i_msg changes are harmless
    assign op = bus_msg_q[MSG_W-2 -: 2];

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        bus_valid_d = 1'b0;
        bus_msg_d   = bus_msg_q;
        resp_d      = resp_q;
        done_d      = '0;
        err_d       = 1'b0;
        cnt_d       = cnt_q;
`ifdef SNOOP_BUS_RR_EN
        ptr_d       = ptr_q;
`endif
        case (state_q)
            S_IDLE: begin
                gnt_d = '0;
                if (pick_any) begin
                    gnt_d       = pick_gnt;
                    bus_msg_d   = bus.i_msg[int'(pick_idx)*MSG_W +: MSG_W];
                    bus_valid_d = 1'b1;
                    state_d     = S_BCAST;
`ifdef SNOOP_BUS_RR_EN
                    ptr_d = (int'(pick_idx) == N_MASTERS - 1) ? '0 : pick_idx + IDX_W'(1);
`endif
                end
            end
            S_BCAST: begin
                if (needs_mem(op)) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else begin
                    state_d = S_DONE;
                    done_d  = gnt_q;
                    resp_d  = '0;
                end
            end
            S_WAIT: begin
                // A response arriving on the expiry cycle still wins.
                if (bus.i_mem_valid) begin
                    state_d = S_DONE;
                    done_d  = gnt_q;
                    resp_d  = bus.i_mem_msg;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = S_DONE;
                    done_d  = gnt_q;
                    resp_d  = '0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                gnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            gnt_q       <= '0;
            bus_valid_q <= 1'b0;
            bus_msg_q   <= '0;
            resp_q      <= '0;
            done_q      <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            bus_valid_q <= bus_valid_d;
            bus_msg_q   <= bus_msg_d;
            resp_q      <= resp_d;
            done_q      <= done_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

`ifdef SNOOP_BUS_RR_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    assign bus.o_gnt       = gnt_q;
    assign bus.o_bus_valid = bus_valid_q;
    assign bus.o_bus_msg   = bus_msg_q;
    assign bus.o_resp_msg  = resp_q;
    assign bus.o_done      = done_q;
    assign bus.o_err       = err_q;

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_snoop_bus_arbiter
// Directed scoreboard bench: stimulus pushes expected broadcasts and
// completions (with the cycle they must appear in); a negedge monitor pops
// and compares whenever o_bus_valid or o_done is presented.
// -----------------------------------------------------------------------------
module tb_snoop_bus_arbiter;

    localparam int N  = 4;
    localparam int MW = 24;
    localparam int TO = 15;

    typedef struct {
        int          cyc;
        logic [3:0]  gnt;
        logic [23:0] msg;
    } bexp_t;

    typedef struct {
        int          cyc;
        logic [3:0]  done;
        logic [23:0] resp;
        logic        err;
    } dexp_t;

    logic i_clk;
    logic i_rst_n;
    int   cyc;
    int   checks;
    int   errors;

    bexp_t bq[$];
    dexp_t dq[$];

    snoop_bus_if #(.N_MASTERS(N), .MSG_W(MW)) bus ();

    snoop_bus_arbiter #(
        .N_MASTERS (N),
        .MSG_W     (MW),
        .TIMEOUT   (TO)
    ) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_msg(input int k, input logic [23:0] m);
        bus.i_msg[k*MW +: MW] = m;
    endtask

    task automatic push_b(input int c, input logic [3:0] g, input logic [23:0] m);
        bexp_t e;
        e.cyc = c; e.gnt = g; e.msg = m;
        bq.push_back(e);
    endtask

    task automatic push_d(input int c, input logic [3:0] d, input logic [23:0] r, input logic er);
        dexp_t e;
        e.cyc = c; e.done = d; e.resp = r; e.err = er;
        dq.push_back(e);
    endtask

    // Request is sampled on the next edge; g is the cycle showing BCAST.
    task automatic start(input logic [3:0] req, output int g);
        bus.i_req = req;
        tick();
        g = cyc;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((bq.size() != 0 || dq.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (bq.size() != 0 || dq.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d/%0d pending expected 0/0", bq.size(), dq.size());
            bq.delete();
            dq.delete();
        end
        tick();
        tick();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"},   32'(bus.o_gnt),       32'h0);
        chk({tag, "_bv"},    32'(bus.o_bus_valid), 32'h0);
        chk({tag, "_bmsg"},  32'(bus.o_bus_msg),   32'h0);
        chk({tag, "_resp"},  32'(bus.o_resp_msg),  32'h0);
        chk({tag, "_done"},  32'(bus.o_done),      32'h0);
        chk({tag, "_err"},   32'(bus.o_err),       32'h0);
    endtask

    // Monitor
    always @(negedge i_clk) begin
        if (bus.o_bus_valid === 1'b1) begin
            if (bq.size() == 0) begin
                chk("bus_unexpected", 32'(bus.o_bus_valid), 32'h0);
            end else begin
                bexp_t e;
                e = bq.pop_front();
                chk("bus_cyc", 32'(cyc), 32'(e.cyc));
                chk("bus_gnt", 32'(bus.o_gnt), 32'(e.gnt));
                chk("bus_msg", 32'(bus.o_bus_msg), 32'(e.msg));
            end
        end
        if (bus.o_done !== 4'b0000) begin
            if (dq.size() == 0) begin
                chk("done_unexpected", 32'(bus.o_done), 32'h0);
            end else begin
                dexp_t e;
                e = dq.pop_front();
                chk("done_cyc",  32'(cyc), 32'(e.cyc));
                chk("done_vec",  32'(bus.o_done), 32'(e.done));
                chk("done_resp", 32'(bus.o_resp_msg), 32'(e.resp));
                chk("done_err",  32'(bus.o_err), 32'(e.err));
                chk("done_gnt",  32'(bus.o_gnt), 32'(e.done));
            end
        end else if (bus.o_err !== 1'b0) begin
            chk("err_without_done", 32'(bus.o_err), 32'h0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        int w;
        checks = 0;
        errors = 0;
        i_rst_n         = 1'b0;
        bus.i_req       = '0;
        bus.i_msg       = '0;
        bus.i_mem_valid = 1'b0;
        bus.i_mem_msg   = '0;
        tick();
        tick();
        chk_all_zero("reset");
        i_rst_n = 1'b1;
        tick();

        // Contention: all four request for four transactions
        for (int i = 0; i < 4; i++) set_msg(i, 24'h400000 + 24'(i));
        start(4'b1111, g);
        for (int i = 0; i < 4; i++) begin
`ifdef SNOOP_BUS_RR_EN
            w = i;
`else
            w = 0;
`endif
            push_b(g + 3*i,     4'(1 << w), 24'h400000 + 24'(w));
            push_d(g + 3*i + 1, 4'(1 << w), 24'h0, 1'b0);
        end
        repeat (9) tick();
        bus.i_req = '0;
        wait_drain(20);

        // Single RM from master 1, response three cycles after BCAST
        set_msg(1, 24'h012345);
        start(4'b0010, g);
        bus.i_req = '0;
        push_b(g, 4'b0010, 24'h012345);
        push_d(g + 4, 4'b0010, 24'h00ABCD, 1'b0);
        repeat (3) tick();
        bus.i_mem_valid = 1'b1;
        bus.i_mem_msg   = 24'h00ABCD;
        tick();
        bus.i_mem_valid = 1'b0;
        bus.i_mem_msg   = '0;
        wait_drain(20);

        // Timeout: master 0 RM without a response
        set_msg(0, 24'h0F0000);
        start(4'b0001, g);
        bus.i_req = '0;
        push_b(g, 4'b0001, 24'h0F0000);
        push_d(g + TO + 1, 4'b0001, 24'h0, 1'b1);
        wait_drain(40);

        // Response on the expiry cycle wins over the timeout
        set_msg(0, 24'h0E1111);
        start(4'b0001, g);
        bus.i_req = '0;
        push_b(g, 4'b0001, 24'h0E1111);
        push_d(g + TO + 1, 4'b0001, 24'h00BEEF, 1'b0);
        repeat (TO) tick();
        bus.i_mem_valid = 1'b1;
        bus.i_mem_msg   = 24'h00BEEF;
        tick();
        bus.i_mem_valid = 1'b0;
        bus.i_mem_msg   = '0;
        wait_drain(40);

        // INV shortcut from master 2, with a stray memory strobe around it
        set_msg(2, 24'h455AA5);
        bus.i_mem_valid = 1'b1;
        bus.i_mem_msg   = 24'hDEAD01;
        start(4'b0100, g);
        bus.i_req = '0;
        push_b(g, 4'b0100, 24'h455AA5);
        push_d(g + 1, 4'b0100, 24'h0, 1'b0);
        tick();
        bus.i_mem_valid = 1'b0;
        bus.i_mem_msg   = '0;
        wait_drain(20);

        // Stale data: master 3 changes its message right after the grant
        set_msg(3, 24'h111111);
        start(4'b1000, g);
        set_msg(3, 24'h222222);
        bus.i_req = '0;
        push_b(g, 4'b1000, 24'h111111);
        push_d(g + 2, 4'b1000, 24'h00FACE, 1'b0);
        tick();
        bus.i_mem_valid = 1'b1;
        bus.i_mem_msg   = 24'h00FACE;
        tick();
        bus.i_mem_valid = 1'b0;
        bus.i_mem_msg   = '0;
        wait_drain(20);

        // Reset mid-WAIT: aborted master gets no completion
        set_msg(1, 24'h0A0B0C);
        start(4'b0010, g);
        bus.i_req = '0;
        push_b(g, 4'b0010, 24'h0A0B0C);
        repeat (4) tick();
        #2;
        i_rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        tick();
        tick();
        i_rst_n = 1'b1;
        tick();
        set_msg(2, 24'h4ABCDE);
        start(4'b0100, g);
        bus.i_req = '0;
        push_b(g, 4'b0100, 24'h4ABCDE);
        push_d(g + 1, 4'b0100, 24'h0, 1'b0);
        wait_drain(20);

        chk("final_bq_empty", 32'(bq.size()), 32'h0);
        chk("final_dq_empty", 32'(dq.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/snoop_bus_arbiter.md
# snoop_bus_arbiter

Registered, parametrised arbiter for the snooping coherence bus. Replaces the combinational priority mux between the processor caches and main memory with an N-master arbiter. It grants one cache at a time, broadcasts that cache's 24-bit coherence message to all snoopers for exactly one cycle, and waits for the memory response or a timeout. It then returns the response to the granted master and releases the bus.

## Interface
Parameters:
- N_MASTERS, 4: number of requesting caches; must be ≥2.
- MSG_W, 24: bus message width; op field is bits [MSG_W-2:MSG_W-3].
- TIMEOUT, 15: maximum cycles spent in WAIT before forced release; must be ≥1.

Ports:
- i_clk  in  1  single clock; all state on rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_req  in  N_MASTERS  per-master request; held until matching o_done bit.
- i_msg  in  N_MASTERS*MSG_W  per-master message; master k at [k*MSG_W +: MSG_W].
- i_mem_valid  in  1  memory response strobe.
- i_mem_msg  in  MSG_W  memory response data.
- o_gnt  out  N_MASTERS  one-hot grant; held from BCAST through DONE.
- o_bus_valid  out  1  broadcast strobe to all snoopers.
- o_bus_msg  out  MSG_W  latched message of the granted master.
- o_resp_msg  out  MSG_W  registered memory response; valid while o_done is high.
- o_done  out  N_MASTERS  one-hot completion pulse to the granted master.
- o_err  out  1  one-cycle pulse coinciding with o_done when completion was caused by timeout.

## Operation
- Op encoding: 0 = RM (read miss), 1 = WM (write miss), 2 = INV (invalidate), 3 = reserved and treated as INV.
- FSM states: IDLE, BCAST, WAIT, DONE.
- IDLE:
  - Clear o_gnt.
  - If any i_req bit is set, select a winner, latch its i_msg into the message register, set o_gnt, and go to BCAST.
- BCAST:
  - o_bus_valid=1 for this cycle only; o_bus_msg carries the latched message.
  - If op is RM or WM, go to WAIT and clear the timeout counter.
  - Otherwise go directly to DONE, with o_resp_msg = 0.
- WAIT:
  - On i_mem_valid, register i_mem_msg into o_resp_msg and go to DONE.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1 without a response, go to DONE with o_err set and o_resp_msg = 0.
  - If a response and expiry occur in the same cycle, the response wins and o_err stays 0.
- DONE:
  - o_done = o_gnt for one cycle; o_err per above.
  - Next state is IDLE.
- i_mem_valid outside WAIT is ignored.
- Deasserting i_req mid-transaction is ignored; the transaction completes normally.
- i_msg changes after the grant cycle do not affect o_bus_msg.
- Counter width is $clog2(TIMEOUT+1) bits and never wraps.
- o_bus_msg holds its last value when o_bus_valid=0.

## Timing
- Requests are sampled in IDLE at edge 0. o_gnt and o_bus_valid are high in cycle 1.
- INV transaction: o_done in cycle 2, bus free in cycle 3. Minimum occupancy is 3 cycles.
- RM/WM transaction: o_done one cycle after the i_mem_valid edge.
- Timed-out transaction: o_done and o_err in cycle TIMEOUT+2.
- The next grant is possible no earlier than the cycle after DONE, so there are no back-to-back grants without one IDLE cycle.
- Reset (asynchronous, any time including mid-transaction):
  - State returns to IDLE.
  - o_gnt, o_bus_valid, o_done, o_err, o_bus_msg, o_resp_msg, the counter and the round-robin pointer all go to 0.
  - The aborted master receives no o_done.

## Configuration
- SNOOP_BUS_RR_EN defined: round-robin arbitration.
  - The pointer holds the index after the last winner, modulo N_MASTERS.
  - The search runs upward from the pointer with wrap-around.
  - The pointer updates on the IDLE→BCAST transition.
- SNOOP_BUS_RR_EN undefined: fixed priority, lowest index wins (master 0 highest), as in the legacy bus. The pointer logic is absent.

## Structure
- Shared package snoop_bus_pkg holds:
  - Op constants OP_RM, OP_WM, OP_INV.
  - The FSM state enum.
  - Field-position localparams for op, tag and data.
- One sub-module, snoop_bus_prio_pick: combinational one-hot picker with a start-index input, used for both arbitration modes (start index tied to 0 when round-robin is disabled).

## Test plan
- Single RM: i_req=4'b0010, master 1 msg 24'h012345; i_mem_valid with 24'h00ABCD three cycles after BCAST → o_bus_valid for 1 cycle with 24'h012345; o_done=4'b0010 with o_resp_msg=24'h00ABCD; o_err=0.
- INV shortcut: master 2 sends op=2 → o_done=4'b0100 exactly 2 cycles after the grant; o_resp_msg=0; no WAIT state entered.
- Timeout: master 0 sends RM with no memory response, TIMEOUT=15 → o_done=4'b0001 and o_err=1 in cycle 17.
  - Repeat with i_mem_valid on the expiry cycle → o_err=0.
- Contention: i_req=4'b1111 held for four transactions.
  - Fixed priority: grant order 0,0,0,0.
  - With SNOOP_BUS_RR_EN: grant order 0,1,2,3.
- Reset mid-WAIT: assert i_rst_n=0 during WAIT → all outputs 0 immediately; after release, a new request is granted normally with o_done only for the new transaction.
- Stale data: master 3 changes i_msg from 24'h111111 to 24'h222222 the cycle after the grant → o_bus_msg=24'h111111.
